m_ptw_mem_port: RTL and testbench
=================================

# m_ptw_mem_port

Memory-side port for the hardware page-table walker. It sits directly downstream of the MMU and turns the walker's PTE read addresses (L1 and L0) and its A/D write-back into single-word DRAM transactions. It returns the PTE word and a busy flag that the MMU consumes as its DRAM data and DRAM-busy inputs, and it raises a mode flag so the top level steers the shared DRAM port to the walker.

## Interface
- `ADDR_W`, default 32: physical address width.
- `DATA_W`, default 32: PTE width. Only 32 is supported.

Ports (name, direction, width, meaning):
- `CLK` in 1: clock.
- `RST` in 1: reset, synchronous, active-high.
- `w_pw_state` in 3: MMU walk state. 1 = L1 read, 2 = L0 address, 3 = L0 read, 5 = PTE update.
- `w_tlb_acs` in 1: MMU says `w_tlb_pte_addr` is valid.
- `w_tlb_pte_addr` in 32: PTE address from the MMU.
- `w_pte_we` in 1: A/D write-back request. Meaningful only when `w_pw_state`==5.
- `w_pte_wdata` in 32: PTE write-back data.
- `w_tlb_flush` in 1: sfence/satp flush.
- `w_ptw_busy` out 1: to the MMU's DRAM-busy input.
- `w_ptw_odata` out 32: registered PTE word, to the MMU's DRAM data input.
- `w_mode_is_ptw` out 1: the walker owns the DRAM port.
- `w_dram_req` out 1: request valid.
- `w_dram_we` out 1: 1 = write.
- `w_dram_addr` out 32: word address.
- `w_dram_wdata` out 32: write data.
- `w_dram_ready` in 1: request accepted this cycle.
- `w_dram_rvalid` in 1: read data valid.
- `w_dram_rdata` in 32: read data.

## Operation
- **Address latch.** `r_addr` loads `w_tlb_pte_addr` on every cycle with `w_tlb_acs`=1 and `w_pw_state`∈{0,2}. The MMU drives address 0 during states 1 and 3, so the latched value is the one used there.
- **FSM states:** IDLE, RD_REQ, RD_WAIT, RD_DONE, WR_REQ.

FSM transitions:
- **IDLE**
  - `w_pw_state`∈{1,3} → RD_REQ. With the buffer feature and a buffer hit in state 1 → RD_DONE instead.
  - `w_pw_state`==5 and `w_pte_we` → WR_REQ. On this edge, capture `w_tlb_pte_addr` into `r_addr` and `w_pte_wdata` into `r_wdata`.
- **RD_REQ:** `w_dram_req`=1, `w_dram_we`=0, `w_dram_addr`=`r_addr`. Held stable until `w_dram_ready`; then → RD_WAIT.
- **RD_WAIT:** on `w_dram_rvalid`, `w_ptw_odata` ← `w_dram_rdata` and → RD_DONE.
- **RD_DONE:** one cycle. → IDLE unconditionally.
- **WR_REQ:** `w_dram_req`=1, `w_dram_we`=1. On `w_dram_ready` → IDLE; the write is complete at that point.

Outputs:
- `w_ptw_busy` = (`w_pw_state`∈{1,3} && FSM≠RD_DONE) || FSM==WR_REQ. It is combinational and high in the first cycle the MMU enters state 1 or 3.
- `w_mode_is_ptw` = FSM∈{RD_REQ, RD_WAIT, WR_REQ}.
- `w_dram_req` is never asserted in IDLE or RD_DONE.

Boundary conditions:
- `w_dram_rvalid` while not in RD_WAIT: ignored.
- `w_pte_we` with `w_pw_state`≠5: ignored.
- `w_tlb_flush` mid-read: the current transaction completes normally. Only the buffer is affected.
- `RST` mid-transaction: FSM → IDLE next cycle, and no further request is issued in that cycle. Any DRAM response in flight is dropped.

## Timing
- **Reset values:** FSM=IDLE, `w_ptw_odata`=0, `w_dram_req`=0, `w_dram_we`=0, `w_mode_is_ptw`=0, buffer invalid. `w_ptw_busy` follows `w_pw_state`.
- **Read latency.** Let cycle N be the MMU's first cycle in state 1.
  - N+1: `w_dram_req`.
  - N+1+a: accepted, where a ≥ 0 is the `w_dram_ready` wait.
  - `w_dram_rvalid` earliest one cycle after acceptance.
  - RD_DONE (busy low) follows the cycle after `w_dram_rvalid`.
  - Minimum: RD_DONE at N+3, and the MMU leaves state 1 at the N+3 edge.
- **Buffer hit:** RD_DONE at N+1.
- **Write.** Request at (state-5 cycle)+1. Busy stays high until acceptance, so the MMU's next walk in state 0 is held off.

## Configuration
- `PTW_L1_BUF_EN` defined:
  - Adds a single-entry L1 PTE buffer (valid, addr, data), filled on every completed state-1 read.
  - A state-1 hit skips DRAM.
  - A write to the buffered address updates the buffered data (write-through).
  - `w_tlb_flush` or `RST` clears valid.
- Not defined: every read goes to DRAM, and no buffer registers are present.

## Structure
- FSM state encodings and the PW-state constants (1, 2, 3, 5) go in `define.vh`, shared with the MMU.
- Sub-module `m_ptw_l1_buf` holds the optional buffer. It is instantiated only under `PTW_L1_BUF_EN`.

## Test plan
- **L1 read:** latched address 0x80001004, `w_pw_state` 0→1, `w_dram_ready`=1, rdata 0x2000_0C01 one cycle later → `w_ptw_busy` low exactly at N+3 with `w_ptw_odata`=0x20000C01.
- **Backpressure:** `w_dram_ready` low for 4 cycles → req, addr and we stay stable; busy stays high throughout; one accepted request.
- **L0 path:** state 2 presents 0x80802010, state 3 → DRAM addr 0x80802010, not 0.
- **A/D update:** state 5, `w_pte_we`=1, addr 0x80802010, wdata 0x200000CF → one write with `w_dram_we`=1. Busy is high in the following state-0 cycle until acceptance.
- **Reset mid-read:** `RST` in RD_WAIT, then rvalid arrives → ignored, FSM IDLE, `w_dram_req`=0.
- **`PTW_L1_BUF_EN`:** two walks to the same L1 address → second walk has no DRAM request and RD_DONE at N+1. After `w_tlb_flush`, the next walk issues a DRAM read.

Source files
------------

// File: rtl/m_ptw_mem_port_pkg.sv
// m_ptw_mem_port_pkg: FSM states and MMU walk-state codes shared by the PTW memory port.
package m_ptw_mem_port_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_RD_DONE, S_WR_REQ} ptw_state_e;
  localparam logic [2:0] PW_IDLE    = 3'd0;
  localparam logic [2:0] PW_L1_RD   = 3'd1;
  localparam logic [2:0] PW_L0_ADDR = 3'd2;
  localparam logic [2:0] PW_L0_RD   = 3'd3;
  localparam logic [2:0] PW_UPDATE  = 3'd5;
  function automatic logic is_rd(input logic [2:0] s);
    return s == PW_L1_RD || s == PW_L0_RD;
  endfunction
endpackage

// File: rtl/m_ptw_mem_port_if.sv
// m_ptw_mem_port_if: MMU-side walk signals and single-word DRAM port of the walker.
interface m_ptw_mem_port_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic [2:0]        w_pw_state;
  logic              w_tlb_acs;
  logic [ADDR_W-1:0] w_tlb_pte_addr;
  logic              w_pte_we;
  logic [DATA_W-1:0] w_pte_wdata;
  logic              w_tlb_flush;
  logic              w_ptw_busy;
  logic [DATA_W-1:0] w_ptw_odata;
  logic              w_mode_is_ptw;
  logic              w_dram_req;
  logic              w_dram_we;
  logic [ADDR_W-1:0] w_dram_addr;
  logic [DATA_W-1:0] w_dram_wdata;
  logic              w_dram_ready;
  logic              w_dram_rvalid;
  logic [DATA_W-1:0] w_dram_rdata;
  modport master (
    output w_pw_state, w_tlb_acs, w_tlb_pte_addr, w_pte_we, w_pte_wdata, w_tlb_flush,
    output w_dram_ready, w_dram_rvalid, w_dram_rdata,
    input  w_ptw_busy, w_ptw_odata, w_mode_is_ptw, w_dram_req, w_dram_we, w_dram_addr, w_dram_wdata
  );
  modport slave (
    input  w_pw_state, w_tlb_acs, w_tlb_pte_addr, w_pte_we, w_pte_wdata, w_tlb_flush,
    input  w_dram_ready, w_dram_rvalid, w_dram_rdata,
    output w_ptw_busy, w_ptw_odata, w_mode_is_ptw, w_dram_req, w_dram_we, w_dram_addr, w_dram_wdata
  );
endinterface

// File: rtl/m_ptw_l1_buf.sv
// m_ptw_l1_buf: single-entry write-through L1 PTE buffer, used only when PTW_L1_BUF_EN is defined.
module m_ptw_l1_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);
  logic              v;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  always_ff @(posedge CLK) begin
    if (RST || flush) v <= 1'b0;
    else if (fill) v <= 1'b1;
    if (fill) begin
      a <= fill_addr;
      d <= fill_data;
    end else if (wr && v && wr_addr == a) d <= wr_data;
  end
  assign hit      = v && lk_addr == a;
  assign hit_data = d;
endmodule

// File: rtl/m_ptw_mem_port.sv
// m_ptw_mem_port: turns walker PTE reads and A/D write-backs into single-word DRAM transactions.
// Optional single-entry L1 PTE buffer under PTW_L1_BUF_EN.
module m_ptw_mem_port
  import m_ptw_mem_port_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic             CLK,
  input logic             RST,
  m_ptw_mem_port_if.slave bus
);
  ptw_state_e        state, next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_odata, buf_data;
  logic              rd_pw, start_wr, buf_hit, hit;
  assign rd_pw    = is_rd(bus.w_pw_state);
  assign start_wr = bus.w_pw_state == PW_UPDATE && bus.w_pte_we;
  assign hit      = buf_hit && bus.w_pw_state == PW_L1_RD;
`ifdef PTW_L1_BUF_EN
  m_ptw_l1_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf (
    .CLK      (CLK),
    .RST      (RST),
    .flush    (bus.w_tlb_flush),
    .fill     (state == S_RD_WAIT && bus.w_dram_rvalid && bus.w_pw_state == PW_L1_RD),
    .fill_addr(r_addr),
    .fill_data(bus.w_dram_rdata),
    .wr       (state == S_WR_REQ && bus.w_dram_ready),
    .wr_addr  (r_addr),
    .wr_data  (r_wdata),
    .lk_addr  (r_addr),
    .hit      (buf_hit),
    .hit_data (buf_data)
  );
`else
  logic unused_flush;
  assign unused_flush = bus.w_tlb_flush;
  assign buf_hit      = 1'b0;
  assign buf_data     = '0;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_odata <= '0;
    end else begin
      state <= next;
      if (bus.w_tlb_acs && (bus.w_pw_state == PW_IDLE || bus.w_pw_state == PW_L0_ADDR)) r_addr <= bus.w_tlb_pte_addr;
      if (state == S_IDLE && start_wr) begin
        r_addr  <= bus.w_tlb_pte_addr;
        r_wdata <= bus.w_pte_wdata;
      end
      if (state == S_RD_WAIT && bus.w_dram_rvalid) r_odata <= bus.w_dram_rdata;
      else if (state == S_IDLE && hit) r_odata <= buf_data;
    end
  end
  always_comb begin
    next = state;
    case (state)
      S_IDLE:    next = rd_pw ? (hit ? S_RD_DONE : S_RD_REQ) : start_wr ? S_WR_REQ : S_IDLE;
      S_RD_REQ:  next = bus.w_dram_ready ? S_RD_WAIT : S_RD_REQ;
      S_RD_WAIT: next = bus.w_dram_rvalid ? S_RD_DONE : S_RD_WAIT;
      S_RD_DONE: next = S_IDLE;
      S_WR_REQ:  next = bus.w_dram_ready ? S_IDLE : S_WR_REQ;
      default:   next = S_IDLE;
    endcase
    // A request is suppressed in the reset cycle so nothing new reaches DRAM.
    bus.w_dram_req    = !RST && (state == S_RD_REQ || state == S_WR_REQ);
    bus.w_dram_we     = !RST && state == S_WR_REQ;
    bus.w_dram_addr   = r_addr;
    bus.w_dram_wdata  = r_wdata;
    bus.w_ptw_odata   = r_odata;
    bus.w_mode_is_ptw = state == S_RD_REQ || state == S_RD_WAIT || state == S_WR_REQ;
    bus.w_ptw_busy    = (rd_pw && state != S_RD_DONE) || state == S_WR_REQ;
  end
endmodule

// File: tb/tb_m_ptw_mem_port.sv
// tb_m_ptw_mem_port: randomized walks checked each cycle against a timeline model of the port.
module tb_m_ptw_mem_port;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;
  m_ptw_mem_port_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  m_ptw_mem_port #(.ADDR_W(32), .DATA_W(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  int n_chk = 0, n_err = 0, cyc = 0, n_acc = 0, e_acc = 0, last_fall = 0, n0 = 0;
  logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;
  logic chk_en = 1'b0, chk_mode = 1'b1, prev_busy = 1'b0;
  logic e_busy = 1'b0, e_req = 1'b0, e_we = 1'b0, e_mode = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_odata = '0;
  logic [31:0] m_raddr = '0, m_odata = '0, ba = '0, bd = '0;
  logic bv = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("busy", 32'(bus.w_ptw_busy), 32'(e_busy));
      chk("dram_req", 32'(bus.w_dram_req), 32'(e_req));
      chk("dram_we", 32'(bus.w_dram_we), 32'(e_we));
      if (chk_mode) chk("mode_is_ptw", 32'(bus.w_mode_is_ptw), 32'(e_mode));
      chk("ptw_odata", bus.w_ptw_odata, e_odata);
      if (e_req) chk("dram_addr", bus.w_dram_addr, e_addr);
      if (e_req && e_we) chk("dram_wdata", bus.w_dram_wdata, e_wdata);
    end
    if (bus.w_dram_req && bus.w_dram_ready) begin
      n_acc++;
      if (bus.w_dram_we) begin
        last_wr_addr = bus.w_dram_addr;
        last_wr_data = bus.w_dram_wdata;
      end else last_rd_addr = bus.w_dram_addr;
    end
    if (prev_busy && !bus.w_ptw_busy) last_fall = cyc;
    prev_busy = bus.w_ptw_busy;
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic quiet();
    RST = 1'b0;
    bus.w_pw_state = 3'd0;
    bus.w_tlb_acs = 1'b0;
    bus.w_tlb_pte_addr = $urandom;
    bus.w_pte_we = 1'b0;
    bus.w_pte_wdata = $urandom;
    bus.w_tlb_flush = 1'b0;
    bus.w_dram_ready = 1'b0;
    bus.w_dram_rvalid = 1'b0;
    bus.w_dram_rdata = $urandom;
    e_busy = 1'b0; e_req = 1'b0; e_we = 1'b0; e_mode = 1'b0;
    e_odata = m_odata;
    chk_mode = 1'b1;
  endtask
  task automatic present(input logic [2:0] pw, input logic [31:0] addr);
    tick(); quiet();
    bus.w_pw_state = pw;
    bus.w_tlb_acs = 1'b1;
    bus.w_tlb_pte_addr = addr;
    bus.w_pte_we = 1'($urandom_range(0, 1));
    m_raddr = addr;
  endtask
  // Timeline of one read walk: k=0 MMU enters state, 1..1+a request, then d wait cycles, then done.
  task automatic rd(input bit l1, input logic [31:0] data, input int a, input int d, input bit fl);
    bit hit;
    logic [2:0] pw;
    hit = 1'b0;
    pw = l1 ? 3'd1 : 3'd3;
`ifdef PTW_L1_BUF_EN
    hit = l1 && bv && ba == m_raddr;
`endif
    tick(); quiet();
    bus.w_pw_state = pw; bus.w_tlb_acs = 1'b1; bus.w_tlb_pte_addr = '0;
    bus.w_dram_rvalid = 1'($urandom_range(0, 1));
    e_busy = 1'b1;
    n0 = cyc;
    if (hit) begin
      tick(); quiet();
      bus.w_pw_state = pw;
      m_odata = bd; e_odata = bd;
      return;
    end
    for (int k = 0; k <= a; k++) begin
      tick(); quiet();
      bus.w_pw_state = pw; bus.w_tlb_acs = 1'b1; bus.w_tlb_pte_addr = '0;
      bus.w_dram_ready = (k == a);
      bus.w_dram_rvalid = 1'($urandom_range(0, 1));
      e_busy = 1'b1; e_req = 1'b1; e_mode = 1'b1; e_addr = m_raddr;
    end
    e_acc++;
    for (int j = 0; j <= d; j++) begin
      tick(); quiet();
      bus.w_pw_state = pw;
      bus.w_dram_rvalid = (j == d);
      if (j == d) bus.w_dram_rdata = data;
      if (fl && j == 0 && d > 0) begin bus.w_tlb_flush = 1'b1; bv = 1'b0; end
      e_busy = 1'b1; e_mode = 1'b1;
    end
    tick(); quiet();
    bus.w_pw_state = pw;
    m_odata = data; e_odata = data;
    if (l1) begin bv = 1'b1; ba = m_raddr; bd = data; end
  endtask
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input int a);
    tick(); quiet();
    bus.w_pw_state = 3'd5; bus.w_pte_we = 1'b1;
    bus.w_tlb_pte_addr = addr; bus.w_pte_wdata = data;
    m_raddr = addr;
    for (int k = 0; k <= a; k++) begin
      tick(); quiet();
      bus.w_dram_ready = (k == a);
      e_busy = 1'b1; e_req = 1'b1; e_we = 1'b1; e_mode = 1'b1; e_addr = addr; e_wdata = data;
    end
    e_acc++;
    if (bv && ba == addr) bd = data;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick(); quiet();
      bus.w_pte_we = 1'($urandom_range(0, 1));
      bus.w_dram_rvalid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin bus.w_tlb_flush = 1'b1; bv = 1'b0; end
    end
  endtask
  task automatic rst_mid(input bit in_wait);
    present(3'd0, 32'h8000_7000 | 32'($urandom_range(0, 255)) << 2);
    tick(); quiet();
    bus.w_pw_state = 3'd1; e_busy = 1'b1;
    if (in_wait) begin
      tick(); quiet();
      bus.w_pw_state = 3'd1; bus.w_dram_ready = 1'b1;
      e_busy = 1'b1; e_req = 1'b1; e_mode = 1'b1; e_addr = m_raddr;
      e_acc++;
      tick(); quiet();
      bus.w_pw_state = 3'd1; e_busy = 1'b1; e_mode = 1'b1;
    end
    tick(); quiet();
    RST = 1'b1; chk_mode = 1'b0;
    m_odata = '0; bv = 1'b0;
    tick(); quiet();
    bus.w_dram_rvalid = 1'b1;
    tick(); quiet();
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 2))
      0: return 32'h8000_1004;
      1: return 32'h8000_2008;
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction
  initial begin
    int ra, wd, acc0;
    logic [31:0] ad;
    quiet();
    RST = 1'b1;
    bus.w_pw_state = 3'd1;
    tick(); quiet();
    RST = 1'b1; bus.w_pw_state = 3'd1; e_busy = 1'b1;
    chk_en = 1'b1;
    tick(); quiet();
    RST = 1'b1;
    present(3'd0, 32'h8000_1004);
    rd(1'b1, 32'h2000_0C01, 0, 0, 1'b0);
    tick(); quiet();
    chk("l1_done_at_N+3", 32'(last_fall - n0), 32'd3);
    chk("l1_odata", bus.w_ptw_odata, 32'h2000_0C01);
    chk("l1_dram_addr", last_rd_addr, 32'h8000_1004);
    present(3'd0, 32'h8000_3008);
    acc0 = n_acc;
    rd(1'b1, $urandom, 4, 1, 1'b0);
    tick(); quiet();
    chk("bp_done_at_N+8", 32'(last_fall - n0), 32'd8);
    chk("bp_one_accept", 32'(n_acc - acc0), 32'd1);
    present(3'd0, 32'h8000_4000);
    rd(1'b1, 32'h2020_0801, 0, 0, 1'b0);
    present(3'd2, 32'h8080_2010);
    rd(1'b0, 32'h2000_00C1, 1, 0, 1'b0);
    tick(); quiet();
    chk("l0_dram_addr", last_rd_addr, 32'h8080_2010);
    wr(32'h8080_2010, 32'h2000_00CF, 2);
    tick(); quiet();
    chk("ad_wr_addr", last_wr_addr, 32'h8080_2010);
    chk("ad_wr_data", last_wr_data, 32'h2000_00CF);
    rst_mid(1'b1);
    rst_mid(1'b0);
`ifdef PTW_L1_BUF_EN
    present(3'd0, 32'h8000_5000);
    rd(1'b1, 32'h1234_5601, 0, 0, 1'b0);
    present(3'd0, 32'h8000_5000);
    acc0 = n_acc;
    rd(1'b1, $urandom, 0, 0, 1'b0);
    tick(); quiet();
    chk("hit_done_at_N+1", 32'(last_fall - n0), 32'd1);
    chk("hit_no_dram", 32'(n_acc), 32'(acc0));
    chk("hit_odata", bus.w_ptw_odata, 32'h1234_5601);
    tick(); quiet();
    bus.w_tlb_flush = 1'b1; bv = 1'b0;
    present(3'd0, 32'h8000_5000);
    rd(1'b1, $urandom, 0, 0, 1'b0);
    tick(); quiet();
    chk("flush_miss_at_N+3", 32'(last_fall - n0), 32'd3);
`endif
    for (int it = 0; it < 80; it++) begin
      ra = $urandom_range(0, 3);
      wd = $urandom_range(0, 3);
      ad = pick();
      case ($urandom_range(0, 3))
        0: begin
          present(3'd0, ad);
          rd(1'b1, $urandom, ra, wd, 1'($urandom_range(0, 1)));
        end
        1: begin
          present(3'd0, ad);
          rd(1'b1, $urandom, ra, wd, 1'b0);
          present(3'd2, $urandom & 32'hFFFF_FFFC);
          rd(1'b0, $urandom, wd, ra, 1'($urandom_range(0, 1)));
        end
        2: wr(ad, $urandom, ra);
        default: idle(wd + 1);
      endcase
    end
    tick(); quiet();
    chk("accept_count", 32'(n_acc), 32'(e_acc));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
